// File: rtl/pc_pkg.sv
// Shared constants for the fetch PC unit: exception codes, default vectors and
// the legal instruction-memory window.
package pc_pkg;

  localparam logic [3:0]  EXC_NONE        = 4'd0;
  localparam logic [3:0]  EXC_ADEL        = 4'd4;

  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_VEC = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_LO     = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_HI     = 32'h0000_6ffc;
  localparam int          DEF_RAS_DEPTH   = 4;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bundle: redirect/stack controls toward the unit (master drives),
// registered PC, fetch exception and predicted return address back (slave drives).
interface fetch_pc_unit_if #(
  parameter int XLEN = 32
);

  logic            en;
  logic            req;
  logic            eret;
  logic [XLEN-1:0] epc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            call_push;
  logic            ret_pop;

  logic [XLEN-1:0] current_pc;
  logic [3:0]      exc;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;

  modport master (
    output en, req, eret, epc, redirect, redirect_pc, call_push, ret_pop,
    input  current_pc, exc, ras_top, ras_valid
  );

  modport slave (
    input  en, req, eret, epc, redirect, redirect_pc, call_push, ret_pop,
    output current_pc, exc, ras_top, ras_valid
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. Push when full overwrites the oldest entry;
// flush clears the occupancy only, entry storage is left as is.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  localparam int          PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            replace;

  // Push+pop rewrites the current top in place; a plain push lands one slot above.
  assign replace = push && pop;
  assign wr_ptr  = replace ? top_ptr : top_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !pop) begin
      top_ptr <= wr_ptr;
      if (count != FULL) count <= count + (PW+1)'(1);
    end else if (pop && !push && count != '0) begin
      top_ptr <= top_ptr - PW'(1);
      count   <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && push) entries[wr_ptr] <= push_addr;
  end

  assign ras_valid = (count != '0);
  assign ras_top   = ras_valid ? entries[top_ptr] : '0;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with prioritised next-PC selection and fetch address check.
// Define FETCH_PC_RAS_EN to build in the return-address stack (pc_ras).
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] HANDLER_VEC = XLEN'(DEF_HANDLER_VEC),
  parameter logic [XLEN-1:0] IMEM_LO     = XLEN'(DEF_IMEM_LO),
  parameter logic [XLEN-1:0] IMEM_HI     = XLEN'(DEF_IMEM_HI),
  parameter int              RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_unit_if.slave bus
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two in 2..16");
  end

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;

  // Exception entry and return bypass the stall; redirect and advance do not.
  always_comb begin
    pc_next = pc_q;
    if (bus.req)                     pc_next = HANDLER_VEC;
    else if (bus.eret)               pc_next = bus.epc;
    else if (bus.en && bus.redirect) pc_next = bus.redirect_pc;
    else if (bus.en)                 pc_next = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_VEC;
    else        pc_q <= pc_next;
  end

  assign bus.current_pc = pc_q;
  assign bus.exc = (pc_q < IMEM_LO || pc_q > IMEM_HI || pc_q[1:0] != 2'b00) ? EXC_ADEL : EXC_NONE;

`ifdef FETCH_PC_RAS_EN
  logic stack_ok;

  assign stack_ok = bus.en && !bus.req && !bus.eret;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.req),
    .push      (bus.call_push && stack_ok),
    .pop       (bus.ret_pop && stack_ok),
    .push_addr (pc_q + XLEN'(8)),
    .ras_top   (bus.ras_top),
    .ras_valid (bus.ras_valid)
  );
`else
  assign bus.ras_top   = '0;
  assign bus.ras_valid = 1'b0;
`endif

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter XLEN, 32, PC and address width in bits.
REQ-002 Parameter RESET_VEC, 32'h0000_3000, PC value loaded by reset.
REQ-003 Parameter HANDLER_VEC, 32'h0000_4180, PC value loaded by an exception/interrupt request.
REQ-004 Parameter IMEM_LO, 32'h0000_3000, lowest legal fetch address.
REQ-005 Parameter IMEM_HI, 32'h0000_6ffc, highest legal fetch address.
REQ-006 Parameter RAS_DEPTH, 4, return-address-stack entries, power of two, 2..16.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-low reset; state is reset on a rising clk edge while reset==0.
REQ-009 en  in  1  fetch advance enable; 0 = stall.
REQ-010 req  in  1  exception/interrupt redirect to HANDLER_VEC.
REQ-011 eret  in  1  return from handler to epc.
REQ-012 epc  in  XLEN  return target for eret.
REQ-013 redirect  in  1  resolved branch/jump redirect.
REQ-014 redirect_pc  in  XLEN  target for redirect.
REQ-015 call_push  in  1  fetched instruction is a call; push current_pc+8.
REQ-016 ret_pop  in  1  fetched instruction is a return; pop stack.
REQ-017 current_pc  out  XLEN  registered fetch PC.
REQ-018 exc  out  4  fetch exception code: 4'd4 (AdEL) or 4'd0.
REQ-019 ras_top  out  XLEN  predicted return address (stack top).
REQ-020 ras_valid  out  1  stack non-empty.

Function
REQ-021 Next-PC priority SHALL be: reset > req > eret > (en & redirect) > (en: current_pc+4) > hold.
REQ-022 req and eret SHALL take effect regardless of en; redirect and sequential advance SHALL require en==1.
REQ-023 req and eret in the same cycle: req SHALL win; eret is ignored.
REQ-024 PC update latency SHALL be one cycle: a selected source appears on current_pc after the next rising edge.
REQ-025 current_pc+4 SHALL wrap modulo 2^XLEN with no flag.
REQ-026 exc SHALL be combinational from current_pc: 4'd4 if current_pc<IMEM_LO, current_pc>IMEM_HI, or current_pc[1:0]!=0; else 4'd0.
REQ-027 Stack push/pop SHALL act only when en==1 and no req/eret in that cycle.
REQ-028 Push SHALL write current_pc+8 at top; count increments, saturating at RAS_DEPTH.
REQ-029 Push when full SHALL overwrite the oldest entry (circular wrap); ras_top becomes the new value.
REQ-030 Pop when empty SHALL be a no-op; ras_valid stays 0.
REQ-031 Simultaneous push and pop SHALL replace the top entry with current_pc+8; count unchanged.
REQ-032 req SHALL flush the stack (count=0) on the same edge it loads HANDLER_VEC.
REQ-033 ras_top SHALL equal the top entry when ras_valid==1, else all zeros.

Reset
REQ-034 On reset: current_pc=RESET_VEC, stack count=0, ras_valid=0, ras_top=0; exc follows current_pc.
REQ-035 Reset SHALL override req, eret, redirect and en in the same cycle, including mid-stall.
REQ-036 Stack entry storage need not be cleared; only count/pointer SHALL reset.

Configuration
REQ-037 Macro FETCH_PC_RAS_EN SHALL compile the return-address stack in.
REQ-038 Without FETCH_PC_RAS_EN: no stack storage, ras_top tied 0, ras_valid tied 0, call_push/ret_pop ignored; PC behaviour unchanged.

Structure
REQ-039 Shared package pc_pkg SHALL hold EXC_NONE=4'd0, EXC_ADEL=4'd4 and the default vector/range constants.
REQ-040 Stack SHALL be sub-module pc_ras (params XLEN, RAS_DEPTH), instantiated only under FETCH_PC_RAS_EN.

Verification
REQ-041 Reset low one edge, then en=1 three cycles -> current_pc 3000, 3004, 3008, 300c; exc=0.
REQ-042 en=0 with req=1 at pc=3010 -> next pc=4180, stack flushed; then eret=1, epc=3014 -> pc=3014.
REQ-043 redirect=1, redirect_pc=6ffe, en=1 -> pc=6ffe, exc=4; redirect_pc=7000 -> exc=4; 6ffc -> exc=0.
REQ-044 RAS_DEPTH=4: five pushes at pcs 3000..3010 -> ras_top=3018, four pops -> ras_valid=0 after 4th, oldest (3008) overwritten; fifth pop no-op.
REQ-045 Push+pop same cycle at pc=3020 with top=3008 -> ras_top=3028, count unchanged; req+eret same cycle -> pc=4180.
